// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: scan sequencer for the 11-channel serial ADC interface.
// Drives en_adc/din_address frame by frame and re-tags each result with the
// channel addressed one frame earlier, because the ADC returns results one
// frame late. Results are streamed and kept in a per-channel bank.
module adc_scan_ctrl #(
  parameter int unsigned NUM_CH      = 11,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_state,
  input  logic              start,
  input  logic              cont,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              adc_state,
  input  logic [11:0]       adc_out,
  output logic              en_adc,
  output logic [7:0]        din_address,
  output logic              res_valid,
  output logic [3:0]        res_ch,
  output logic [11:0]       res_data,
  input  logic [3:0]        rd_ch,
  output logic [11:0]       rd_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [4:0]  NUM_CH_L = 5'(NUM_CH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [NUM_CH-1:0] r_mask;
  logic              r_cont;
  logic              r_first;
  logic              r_flush;
  logic [3:0]        r_cur;
  logic [3:0]        r_prev;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_adc_q1;
  logic              r_adc_q2;
  logic [11:0]       r_bank [16];

  logic              w_rise;
  logic              w_tc;
  logic              w_accept;
  logic              w_abort;
  logic [3:0]        w_low;
  logic [3:0]        w_next;
  logic              w_has_next;

  logic              w_en_nxt;
  logic [7:0]        w_din_nxt;
  logic              w_res_valid_nxt;
  logic [3:0]        w_res_ch_nxt;
  logic [11:0]       w_res_data_nxt;
  logic              w_done_nxt;
  logic              w_err_nxt;
  logic              w_busy_nxt;
  logic              w_bank_we;

  assign w_rise   = r_adc_q1 & ~r_adc_q2;
  assign w_tc     = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign w_accept = start & key_state & (|ch_mask);
  assign w_abort  = (r_state != S_IDLE) & ~key_state;

  // Lowest enabled channel, and the next enabled channel above r_cur
  always_comb begin
    w_low      = 4'd0;
    w_next     = 4'd0;
    w_has_next = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_mask[i]) begin
        w_low = 4'(i);
        if (4'(i) > r_cur) begin
          w_next     = 4'(i);
          w_has_next = 1'b1;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; a dropped key_state overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = S_LAUNCH;
      S_LAUNCH:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_rise)    w_state_nxt = S_CAPTURE;
        else if (w_tc) w_state_nxt = S_IDLE;
      end
      S_CAPTURE: begin
        if (w_has_next || !r_flush) w_state_nxt = S_WAIT;
        else                        w_state_nxt = S_FINISH;
      end
      S_FINISH:  w_state_nxt = (r_cont && key_state) ? S_LAUNCH : S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  // Output logic: next values of the registered outputs and bank write enable
  always_comb begin
    w_en_nxt        = en_adc;
    w_din_nxt       = din_address;
    w_res_valid_nxt = 1'b0;
    w_res_ch_nxt    = res_ch;
    w_res_data_nxt  = res_data;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_bank_we       = 1'b0;
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    if (w_abort) begin
      w_en_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !(|ch_mask)) w_done_nxt = 1'b1;
        end
        S_LAUNCH: begin
          w_en_nxt  = 1'b1;
          w_din_nxt = {w_low, 4'b0000};
        end
        S_WAIT: begin
          if (!w_rise && w_tc) begin
            w_err_nxt = 1'b1;
            w_en_nxt  = 1'b0;
          end
        end
        S_CAPTURE: begin
          if (!r_first) begin
            w_res_valid_nxt = 1'b1;
            w_res_ch_nxt    = r_prev;
            w_res_data_nxt  = adc_out;
            w_bank_we       = 1'b1;
          end
          if (w_has_next) w_din_nxt = {w_next, 4'b0000};
        end
        S_FINISH: begin
          w_en_nxt   = 1'b0;
          w_done_nxt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_adc      <= 1'b0;
      din_address <= 8'h00;
      res_valid   <= 1'b0;
      res_ch      <= 4'd0;
      res_data    <= 12'h000;
      done        <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      en_adc      <= w_en_nxt;
      din_address <= w_din_nxt;
      res_valid   <= w_res_valid_nxt;
      res_ch      <= w_res_ch_nxt;
      res_data    <= w_res_data_nxt;
      done        <= w_done_nxt;
      err         <= w_err_nxt;
      busy        <= w_busy_nxt;
    end
  end

  // Scan bookkeeping: mask/mode latch, channel pointers, frame flags, timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask  <= '0;
      r_cont  <= 1'b0;
      r_cur   <= 4'd0;
      r_prev  <= 4'd0;
      r_first <= 1'b0;
      r_flush <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_cnt <= (r_state == S_WAIT) ? r_cnt + CNT_W'(1) : '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mask <= ch_mask;
            r_cont <= cont;
          end
        end
        S_LAUNCH: begin
          r_cur   <= w_low;
          r_first <= 1'b1;
          r_flush <= 1'b0;
        end
        S_CAPTURE: begin
          r_prev  <= r_cur;
          r_first <= 1'b0;
          if (w_has_next) r_cur   <= w_next;
          else            r_flush <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered copies of adc_state for frame-end edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_adc_q1 <= 1'b0;
      r_adc_q2 <= 1'b0;
    end else begin
      r_adc_q1 <= adc_state;
      r_adc_q2 <= r_adc_q1;
    end
  end

  // Per-channel result bank; entries at or above NUM_CH are never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_bank[i] <= 12'h000;
    end else if (w_bank_we) begin
      r_bank[r_prev] <= adc_out;
    end
  end

  // Combinational bank read, zero for out-of-range channels
  assign rd_data = ({1'b0, rd_ch} < NUM_CH_L) ? r_bank[rd_ch] : 12'h000;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Bench for adc_scan_ctrl: a pipelined ADC responder returns per-channel values
// one frame late; observed streams are compared with a channel-list model.
module tb_adc_scan_ctrl;

  localparam int unsigned NCH  = 11;
  localparam int unsigned TOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_state = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic [10:0] ch_mask = '0;
  logic [3:0]  rd_ch = '0;
  logic        w_adc_state;
  logic [11:0] w_adc_out;
  logic        en_adc, res_valid, busy, done, err;
  logic [7:0]  din_address;
  logic [3:0]  res_ch;
  logic [11:0] res_data, rd_data;

  // ADC responder state and manual override
  logic        m_state = 1'b0;
  logic [11:0] m_out = '0;
  logic [15:0] m_cnt = '0;
  logic [15:0] m_len = 16'd8;
  logic [7:0]  m_addr = '0;
  logic [7:0]  m_prev = '0;
  logic        m_have_prev = 1'b0;
  logic        tb_hold = 1'b0;
  logic        tb_manual = 1'b0;
  logic        man_state = 1'b0;
  logic [11:0] man_out = '0;

  logic [11:0] chan_val [16];
  logic [11:0] exp_bank [16];

  logic [15:0] res_q [$];
  int          res_cyc [$];
  int          done_q [$];
  logic [7:0]  addr_q [$];
  int          err_cnt = 0;
  int          cyc = 0;

  logic [15:0] exp_r [$];
  logic [7:0]  exp_a [$];

  int n_vec = 0;
  int n_err = 0;

  assign w_adc_state = tb_manual ? man_state : m_state;
  assign w_adc_out   = tb_manual ? man_out   : m_out;

  adc_scan_ctrl #(.NUM_CH(NCH), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .rst(rst), .key_state(key_state), .start(start), .cont(cont),
    .ch_mask(ch_mask), .adc_state(w_adc_state), .adc_out(w_adc_out),
    .en_adc(en_adc), .din_address(din_address), .res_valid(res_valid),
    .res_ch(res_ch), .res_data(res_data), .rd_ch(rd_ch), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Pipelined ADC: latches the address early in a frame, and at frame end
  // returns the value of the address latched in the previous frame.
  always @(posedge clk) begin
    #1;
    if (rst || !en_adc) begin
      m_cnt       <= '0;
      m_state     <= 1'b0;
      m_have_prev <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 16'd1;
      if (m_cnt == 16'd2) begin
        m_addr <= din_address;
        addr_q.push_back(din_address);
      end
      if (m_cnt == m_len && !tb_hold) begin
        m_state     <= 1'b1;
        m_out       <= m_have_prev ? chan_val[m_prev[7:4]] : 12'hEEE;
        m_prev      <= m_addr;
        m_have_prev <= 1'b1;
      end
      if (m_cnt == m_len + 16'd4 && !tb_hold) begin
        m_state <= 1'b0;
        m_cnt   <= '0;
        m_len   <= 16'($urandom_range(6, 20));
      end
    end
  end

  // Output monitor
  always @(posedge clk) begin
    #1;
    cyc <= cyc + 1;
    if (res_valid) begin
      res_q.push_back({res_ch, res_data});
      res_cyc.push_back(cyc);
    end
    if (done) done_q.push_back(cyc);
    if (err) err_cnt <= err_cnt + 1;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    res_q.delete(); res_cyc.delete(); done_q.delete(); addr_q.delete();
  endtask

  task automatic check_bank();
    for (int c = 0; c < 16; c++) begin
      rd_ch = 4'(c);
      #1;
      chk($sformatf("bank[%0d]", c), 32'(rd_data), 32'(exp_bank[c]));
    end
  endtask

  // One single-shot scan, checked against the ascending-channel model
  task automatic run_scan(input logic [10:0] mask, input bit keep_vals);
    int e0;
    e0 = err_cnt;
    if (!keep_vals) for (int c = 0; c < 16; c++) chan_val[c] = 12'($urandom);
    exp_r.delete(); exp_a.delete();
    for (int c = 0; c < NCH; c++)
      if (mask[c]) begin
        exp_r.push_back({4'(c), chan_val[c]});
        exp_a.push_back({4'(c), 4'h0});
      end
    exp_a.push_back(exp_a[exp_a.size()-1]);
    clear_obs();
    @(negedge clk); ch_mask = mask; cont = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    @(negedge clk);
    chk("en_after_launch", 32'(en_adc), 32'd1);
    chk("din_first", 32'(din_address), 32'(exp_a[0]));
    for (int i = 0; i < 3000 && done_q.size() == 0; i++) @(negedge clk);
    chk("scan_done_seen", 32'(done_q.size()), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("res_count", 32'(res_q.size()), 32'(exp_r.size()));
    for (int i = 0; i < exp_r.size() && i < res_q.size(); i++)
      chk($sformatf("res[%0d]", i), 32'(res_q[i]), 32'(exp_r[i]));
    chk("frame_count", 32'(addr_q.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < addr_q.size(); i++)
      chk($sformatf("addr[%0d]", i), 32'(addr_q[i]), 32'(exp_a[i]));
    if (res_cyc.size() > 0 && done_q.size() > 0)
      chk("done_latency", 32'(done_q[0] - res_cyc[res_cyc.size()-1]), 32'd1);
    chk("no_err_in_scan", 32'(err_cnt - e0), 32'd0);
    for (int c = 0; c < NCH; c++) if (mask[c]) exp_bank[c] = chan_val[c];
  endtask

  initial begin
    int k, got, e0, drops;
    for (int c = 0; c < 16; c++) begin chan_val[c] = '0; exp_bank[c] = '0; end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_en", 32'(en_adc), 32'd0);
    chk("rst_din", 32'(din_address), 32'd0);
    chk("rst_outs", 32'({res_valid, done, err, res_ch, res_data}), 32'd0);
    rst = 1'b0;
    key_state = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 32'({busy, en_adc, done, err}), 32'd0);
    check_bank();

    // Directed two-channel scan
    for (int c = 0; c < 16; c++) chan_val[c] = 12'($urandom);
    chan_val[0] = 12'h123;
    chan_val[2] = 12'hABC;
    run_scan(11'h005, 1'b1);
    rd_ch = 4'd2; #1;
    chk("rd_ch2", 32'(rd_data), 32'h0ABC);

    // Highest channel only
    run_scan(11'h400, 1'b0);

    // Zero mask: immediate done, no frames
    clear_obs();
    @(negedge clk); ch_mask = 11'h000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("zmask_done", 32'(done), 32'd1);
    chk("zmask_busy", 32'({busy, en_adc}), 32'd0);
    @(negedge clk);
    chk("zmask_done_pulse", 32'(done), 32'd0);
    repeat (10) @(negedge clk);
    chk("zmask_no_res", 32'(res_q.size()), 32'd0);
    chk("zmask_no_frames", 32'(addr_q.size()), 32'd0);
    chk("zmask_done_count", 32'(done_q.size()), 32'd1);

    // Random masks
    for (int n = 0; n < 4; n++) run_scan(11'($urandom_range(1, 2047)), 1'b0);
    check_bank();

    // Frame timeout with adc_state held low
    clear_obs();
    e0 = err_cnt;
    tb_hold = 1'b1;
    @(negedge clk); ch_mask = 11'h012; start = 1'b1;
    @(negedge clk); start = 1'b0;
    got = 0; k = 0;
    for (int i = 1; i <= int'(TOUT) + 20 && got == 0; i++) begin
      @(negedge clk);
      if (i == int'(TOUT)) chk("to_en_before_tc", 32'({en_adc, err}), 32'b10);
      if (err) begin
        got = 1; k = i;
        chk("to_en_off", 32'(en_adc), 32'd0);
        chk("to_idle", 32'(busy), 32'd0);
      end
    end
    chk("to_err_seen", 32'(got), 32'd1);
    chk("to_err_latency", 32'(k), 32'(TOUT + 1));
    @(negedge clk);
    chk("to_err_pulse", 32'(err), 32'd0);
    chk("to_err_count", 32'(err_cnt - e0), 32'd1);
    chk("to_no_done", 32'(done_q.size()), 32'd0);
    tb_hold = 1'b0;

    // Rise coincident with terminal count is taken, no err
    clear_obs();
    e0 = err_cnt;
    tb_manual = 1'b1;
    @(negedge clk); ch_mask = 11'h020; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 1; i <= int'(TOUT) + 30; i++) begin
      @(negedge clk);
      if (i == int'(TOUT) - 1) begin man_state = 1'b1; man_out = 12'h0EE; end
      if (i == int'(TOUT) + 3) man_state = 1'b0;
      if (i == int'(TOUT) + 6) begin man_state = 1'b1; man_out = 12'h5A5; end
      if (i == int'(TOUT) + 9) man_state = 1'b0;
    end
    chk("tc_no_err", 32'(err_cnt - e0), 32'd0);
    chk("tc_res_count", 32'(res_q.size()), 32'd1);
    if (res_q.size() > 0) chk("tc_res", 32'(res_q[0]), 32'h55A5);
    chk("tc_done", 32'(done_q.size()), 32'd1);
    exp_bank[5] = 12'h5A5;
    tb_manual = 1'b0;

    // Asynchronous reset mid-scan clears outputs and bank
    for (int c = 0; c < 16; c++) chan_val[c] = 12'($urandom);
    clear_obs();
    @(negedge clk); ch_mask = 11'h7FF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3000 && res_q.size() < 2; i++) @(negedge clk);
    chk("mrst_progress", 32'(res_q.size()), 32'd2);
    rd_ch = 4'd0;
    #2 rst = 1'b1;
    #1;
    chk("mrst_outs", 32'({busy, en_adc, res_valid, done, err}), 32'd0);
    chk("mrst_bank0", 32'(rd_data), 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 16; c++) exp_bank[c] = '0;
    check_bank();

    // Abort by key_state after four results
    for (int c = 0; c < 16; c++) chan_val[c] = 12'($urandom);
    clear_obs();
    e0 = err_cnt;
    @(negedge clk); ch_mask = 11'h7FF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3000 && res_q.size() < 4; i++) @(negedge clk);
    chk("abort_reach4", 32'(res_q.size()), 32'd4);
    key_state = 1'b0;
    @(negedge clk);
    chk("abort_en_off", 32'(en_adc), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    repeat (60) @(negedge clk);
    chk("abort_no_done", 32'(done_q.size()), 32'd0);
    chk("abort_no_err", 32'(err_cnt - e0), 32'd0);
    chk("abort_res_count", 32'(res_q.size()), 32'd4);
    key_state = 1'b1;
    for (int c = 0; c < 4; c++) exp_bank[c] = chan_val[c];
    check_bank();

    // Continuous mode, with ignored start pulses while busy
    for (int c = 0; c < 16; c++) chan_val[c] = 12'($urandom);
    clear_obs();
    drops = 0;
    @(negedge clk); ch_mask = 11'h003; cont = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0; cont = 1'b0;
    for (int i = 0; i < 4000 && done_q.size() < 3; i++) begin
      @(negedge clk);
      if (!busy) drops++;
      if (i % 9 == 4) begin ch_mask = 11'h7FF; start = 1'b1; end
      else start = 1'b0;
    end
    start = 1'b0;
    chk("cont_done_count", 32'(done_q.size() >= 3), 32'd1);
    chk("cont_busy_held", 32'(drops), 32'd0);
    chk("cont_res_count", 32'(res_q.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < res_q.size(); i++)
      chk($sformatf("cont_res[%0d]", i), 32'(res_q[i]),
          32'({4'(i % 2), chan_val[i % 2]}));
    chk("cont_frames", 32'(addr_q.size() >= 9), 32'd1);
    for (int i = 0; i < 9 && i < addr_q.size(); i++)
      chk($sformatf("cont_addr[%0d]", i), 32'(addr_q[i]),
          32'((i % 3 == 0) ? 8'h00 : 8'h10));
    key_state = 1'b0;
    repeat (2) @(negedge clk);
    chk("cont_stop", 32'({busy, en_adc}), 32'd0);
    key_state = 1'b1;
    exp_bank[0] = chan_val[0];
    exp_bank[1] = chan_val[1];
    check_bank();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

Scan sequencer for the 11-channel serial ADC interface block. Accepts a scan request with a channel mask, drives the interface's `en_adc`/`din_address` frame by frame, and compensates for the ADC's one-frame result pipeline: the result read during frame k belongs to the address sent in frame k-1. Publishes each result as a valid-tagged stream and stores it in a per-channel result bank for the classification datapath.

## Interface
- `NUM_CH`, default 11: number of analog channels. Channel codes run 0..NUM_CH-1; NUM_CH ≤ 16.
- `TIMEOUT_CYC`, default 4096: maximum clk cycles allowed per frame.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous reset, active-high.
- `key_state` in 1: global run enable. Low aborts any scan.
- `start` in 1: scan request. Sampled only in IDLE.
- `cont` in 1: continuous mode. Sampled with `start`.
- `ch_mask` in NUM_CH: enabled channels. Latched on accepted `start`.
- `adc_state` in 1: from the ADC interface. A 0→1 edge marks frame end.
- `adc_out` in 12: from the ADC interface. Valid from the cycle after the `adc_state` rise.
- `en_adc` out 1: enable to the ADC interface.
- `din_address` out 8: ADC command, always `{ch[3:0], 4'b0000}` (12-bit, MSB-first, unipolar).
- `res_valid` out 1: one-cycle result strobe.
- `res_ch` out 4: channel of `res_data`.
- `res_data` out 12: conversion result.
- `rd_ch` in 4: result-bank read address.
- `rd_data` out 12: combinational read of bank[rd_ch]. Returns 0 when rd_ch ≥ NUM_CH.
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse at scan completion.
- `err` out 1: one-cycle pulse on frame timeout.

## Operation
- **Reset values:** all outputs 0, all bank entries 0, state IDLE.
- **States:** IDLE, LAUNCH, WAIT, CAPTURE, FINISH.
- **IDLE**
  - `start & key_state` with a nonzero mask: latch the mask, set `cur` to the lowest set bit, clear the frame index. Go to LAUNCH.
  - `start` with an all-zero mask: pulse `done` next cycle, no frames.
- **LAUNCH**
  - `en_adc`←1.
  - `din_address`←{cur,0000}.
  - Go to WAIT.
- **WAIT**
  - Count cycles.
  - Edge detect on `adc_state` uses a registered copy of it; the rise is taken from the edge detector.
  - On rise: go to CAPTURE.
  - On count = TIMEOUT_CYC-1: pulse `err`, `en_adc`←0, go to IDLE.
- **CAPTURE** (one cycle, the cycle after the rise)
  - Frame 0 result is discarded.
  - Otherwise write `adc_out` to `res_data` and to bank[prev], set `res_ch`=prev, pulse `res_valid`.
  - Then `prev`←`cur`.
  - If more mask bits remain above `cur`: advance `cur` to the next set bit, update `din_address`, go to WAIT.
  - Else if the flush frame is not yet done: keep `din_address` (repeat last channel), mark the flush frame, go to WAIT.
  - Else go to FINISH.
- **Address update:** `din_address` changes only in LAUNCH or CAPTURE, which falls inside the ADC conversion gap, so it is never changed while a frame is shifting.
- **FINISH**
  - `en_adc`←0, pulse `done`.
  - If `cont` was latched and `key_state`=1: relaunch with the same mask (LAUNCH).
  - Else go to IDLE.
- **Frame count:** a scan of M enabled channels uses exactly M+1 frames and produces M results in ascending channel order.
- **Abort:** `key_state`=0 in any non-IDLE state → IDLE next cycle, `en_adc`=0. No `done` or `err`; the bank keeps completed entries.
- **Concurrent `start`:** `start` while busy is ignored.

## Timing
- `start` accepted at edge 0 → `busy`=1 after edge 0 → LAUNCH → `en_adc`=1 and `din_address` valid after edge 1.
- `adc_state` rise at edge R → CAPTURE after edge R+1 → `res_valid` and `res_data` visible after edge R+2. The bank entry is written at the same edge.
- `done` is visible 1 cycle after the last CAPTURE. `busy` falls with `done` unless relaunching.
- **Timeout boundary:** an `adc_state` rise in the same cycle as terminal count wins. The rise is taken and no `err` is raised.
- **Mid-scan reset:** `rst` asserted mid-scan clears everything asynchronously, including the bank.

## Test plan
- Mask=0x005, ADC model returns 0x123 (ch0) and 0xABC (ch2):
  - 3 frames, addresses 0x00, 0x20, 0x20.
  - `res_valid` twice: (0,0x123), then (2,0xABC).
  - `done` once; `rd_ch`=2 returns 0xABC.
- Mask=0x400 (ch10 only):
  - 2 frames, both with `din_address`=0xA0.
  - Single result tagged ch10.
- Mask=0: `done` 1 cycle after `start`; `en_adc` stays 0, no `res_valid`.
- `adc_state` held low after LAUNCH: `err` exactly TIMEOUT_CYC cycles into WAIT; `en_adc`=0; state IDLE.
- `key_state` dropped mid-scan (mask=0x7FF, after 4 results):
  - `en_adc`=0 next cycle, no `done`.
  - Bank entries 0..3 hold results; entries 4..10 hold 0.
- `cont`=1, mask=0x003:
  - Back-to-back scans with `done` per scan.
  - `start` pulses while busy have no effect.
